// File: rtl/param_universal_shift_reg_if.sv
// Bus bundle for param_universal_shift_reg: control, parallel and
// serial data in, register contents, serial taps and word counter out.
// Ports (master view): out en, mode, p_din, s_left_din, s_right_din;
// in p_dout, s_left_dout, s_right_dout, shift_cnt, word_done.
// CNT_W = clog2(NSHIFT+1), NSHIFT = ceil(WIDTH/STEP).
interface param_universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
);
    localparam int NSHIFT = (WIDTH + STEP - 1) / STEP;
    localparam int CNT_W  = $clog2(NSHIFT + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] p_din;
    logic [STEP-1:0]  s_left_din;
    logic [STEP-1:0]  s_right_din;
    logic [WIDTH-1:0] p_dout;
    logic [STEP-1:0]  s_left_dout;
    logic [STEP-1:0]  s_right_dout;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, p_din, s_left_din, s_right_din,
        input  p_dout, s_left_dout, s_right_dout,
        input  shift_cnt, word_done
    );

    modport slave (
        input  en, mode, p_din, s_left_din, s_right_din,
        output p_dout, s_left_dout, s_right_dout,
        output shift_cnt, word_done
    );
endinterface

// File: rtl/param_universal_shift_reg.sv
// Universal shift register: hold, logical/arith shifts, rotates,
// parallel load and clear, STEP bits per operation, one-cycle latency.
// Ports: clk, rst (sync, active-high), bus (slave modport of
// param_universal_shift_reg_if).
// Build option: define USR_SHIFT_COUNT_EN to build the per-word shift
// counter (shift_cnt, word_done); otherwise both outputs are tied to 0.
module param_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    param_universal_shift_reg_if.slave    bus
);
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (bus.en) begin
            unique case (bus.mode)
                MODE_HOLD:  data_d = data_q;
                MODE_SHR:   data_d = {bus.s_right_din,
                                      data_q[WIDTH-1:STEP]};
                MODE_SHL:   data_d = {data_q[WIDTH-1-STEP:0],
                                      bus.s_left_din};
                MODE_LOAD:  data_d = bus.p_din;
                MODE_ROR:   data_d = {data_q[STEP-1:0],
                                      data_q[WIDTH-1:STEP]};
                MODE_ROL:   data_d = {data_q[WIDTH-1-STEP:0],
                                      data_q[WIDTH-1 -: STEP]};
                MODE_ASR:   data_d = {{STEP{data_q[WIDTH-1]}},
                                      data_q[WIDTH-1:STEP]};
                MODE_CLEAR: data_d = '0;
                default:    data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.p_dout       = data_q;
    assign bus.s_left_dout  = data_q[WIDTH-1 -: STEP];
    assign bus.s_right_dout = data_q[STEP-1:0];

`ifdef USR_SHIFT_COUNT_EN
    localparam int NSHIFT = (WIDTH + STEP - 1) / STEP;
    localparam int CNT_W  = $clog2(NSHIFT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSHIFT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             is_shift;
    logic             is_restart;

    always_comb begin
        is_shift   = 1'b0;
        is_restart = 1'b0;
        unique case (bus.mode)
            MODE_SHR, MODE_SHL, MODE_ROR,
            MODE_ROL, MODE_ASR:   is_shift   = 1'b1;
            MODE_LOAD, MODE_CLEAR: is_restart = 1'b1;
            default: begin
                is_shift   = 1'b0;
                is_restart = 1'b0;
            end
        endcase
    end

    // The count never reaches NSHIFT: the shift that would complete the
    // word wraps it to 0 and raises the registered done pulse instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.en) begin
                if (is_shift) begin
                    if (cnt_q == LAST) begin
                        cnt_q  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else if (is_restart) begin
                    cnt_q <= '0;
                end
            end
        end
    end

    assign bus.shift_cnt = cnt_q;
    assign bus.word_done = done_q;
`else
    assign bus.shift_cnt = '0;
    assign bus.word_done = 1'b0;
`endif
endmodule

// File: doc/param_universal_shift_reg.md
PARAM_UNIVERSAL_SHIFT_REG -- requirements
Module: param_universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter STEP, default 1, bits moved per shift/rotate operation; SHALL satisfy 1 <= STEP <= WIDTH-1.
REQ-003 Derived constant NSHIFT = ceil(WIDTH/STEP), the number of shifts per full word.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  operation enable; 0 SHALL freeze all state.
REQ-007 mode  input  3  operation select, per REQ-011.
REQ-008 p_din  input  WIDTH  parallel load data.
REQ-009 s_left_din / s_right_din  input  STEP each  serial data shifted in on left-shift / right-shift respectively.
REQ-010 p_dout  output  WIDTH  register contents; s_left_dout  output  STEP  = p_dout[WIDTH-1 -: STEP]; s_right_dout  output  STEP  = p_dout[STEP-1:0]; shift_cnt  output  clog2(NSHIFT+1)  shifts since last load/clear; word_done  output  1  one-cycle pulse.

Function
REQ-011 With en=1, the next p_dout SHALL be: 000 hold; 001 logical right {s_right_din, p_dout[WIDTH-1:STEP]}; 010 logical left {p_dout[WIDTH-1-STEP:0], s_left_din}; 011 load p_din; 100 rotate right by STEP; 101 rotate left by STEP; 110 arithmetic right by STEP (p_dout[WIDTH-1] replicated into top STEP bits); 111 clear to 0.
REQ-012 With en=0, p_dout, shift_cnt SHALL hold and word_done SHALL be 0 next cycle, regardless of mode.
REQ-013 Shift-class modes are 001, 010, 100, 101, 110; with en=1 each SHALL increment shift_cnt by 1.
REQ-014 When a shift-class op takes shift_cnt from NSHIFT-1 to NSHIFT, shift_cnt SHALL instead wrap to 0 and word_done SHALL be 1 for exactly the following cycle.
REQ-015 Modes 011 and 111 with en=1 SHALL set shift_cnt to 0 and word_done to 0; mode 000 SHALL hold shift_cnt and drive word_done 0.
REQ-016 word_done SHALL be registered; it SHALL never be high two consecutive cycles unless NSHIFT=1 and shifts are back-to-back.
REQ-017 s_left_dout and s_right_dout SHALL be combinational slices of registered p_dout (no extra latency).
REQ-018 Latency of every operation SHALL be one clock edge; no operation spans multiple cycles.

Reset
REQ-019 rst=1 at a rising edge SHALL set p_dout=0, shift_cnt=0, word_done=0, with priority over en and mode.
REQ-020 rst asserted mid-word SHALL discard the partial shift count; no word_done SHALL be produced for the interrupted word.
REQ-021 The first edge after rst deasserts SHALL execute the presented mode normally.

Configuration
REQ-022 Macro USR_SHIFT_COUNT_EN: when defined, shift_cnt and word_done SHALL behave per REQ-013..016.
REQ-023 When USR_SHIFT_COUNT_EN is undefined, the counter logic SHALL not be built; shift_cnt and word_done ports SHALL remain and be tied to 0; p_dout behaviour SHALL be unchanged.

Verification
REQ-024 WIDTH=8, STEP=1: load 8'hB5, then mode 001 with s_right_din=0 -> p_dout=8'h5A, s_right_dout=0, s_left_dout=0.
REQ-025 WIDTH=8, STEP=1 from 8'hB5: mode 010 s_left_din=1 -> 8'h6B; mode 100 -> 8'hDA; mode 101 -> 8'h6B; mode 110 -> 8'hDA; mode 111 -> 8'h00.
REQ-026 Counter, WIDTH=8, STEP=1: load, then 8 consecutive mode-001 cycles -> shift_cnt 1..7 then 0, word_done=1 only in the cycle after the 8th edge; WIDTH=8, STEP=2 -> word_done after the 4th shift.
REQ-027 Enable/hold: mid-word, en=0 for 3 cycles with mode=001 -> p_dout and shift_cnt unchanged, word_done=0; resuming completes the word at the correct count.
REQ-028 Reset mid-word: after 5 shifts assert rst one cycle with en=1, mode=011 -> p_dout=0, shift_cnt=0, word_done=0; no pulse for the aborted word.
REQ-029 Build without USR_SHIFT_COUNT_EN: rerun REQ-024..026 -> identical p_dout, shift_cnt and word_done constantly 0.
